// File: rtl/blink_pattern_scheduler.sv
// Round-robin scheduler sharing one LED between NUM_REQ blink-pattern requesters.
// Optional macro BLINK_SCHED_ABORT_EN adds an ABORT input that cancels the current message.
module blink_pattern_scheduler #(
    parameter int NUM_REQ       = 2,
    parameter int MESSAGE_WIDTH = 102,
    parameter int TICK_RATE     = 5_000_000,
    parameter int GAP_TICKS     = 3,
    localparam int LW           = $clog2(MESSAGE_WIDTH + 1)
) (
    input  logic                             CLK,
    input  logic                             RST,
`ifdef BLINK_SCHED_ABORT_EN
    input  logic                             ABORT,
`endif
    input  logic [NUM_REQ-1:0]               REQ_VALID,
    output logic [NUM_REQ-1:0]               REQ_READY,
    input  logic [NUM_REQ*MESSAGE_WIDTH-1:0] REQ_PATTERN,
    input  logic [NUM_REQ*LW-1:0]            REQ_LEN,
    output logic                             LED,
    output logic                             START,
    output logic                             BUSY,
    output logic [NUM_REQ-1:0]               GRANT,
    output logic                             DONE
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = (TICK_RATE > 1) ? $clog2(TICK_RATE) : 1;
    localparam int BW = (MESSAGE_WIDTH > 1) ? $clog2(MESSAGE_WIDTH) : 1;
    localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]               state;
    logic [PW-1:0]            rr_ptr;
    logic [TW-1:0]            tick;
    logic [BW-1:0]            bit_idx;
    logic [GW-1:0]            gap_idx;
    logic [LW-1:0]            len;
    logic [MESSAGE_WIDTH-1:0] pattern;
    logic [NUM_REQ-1:0]       grant;

    logic                     found;
    logic [PW-1:0]            sel;
    logic [PW:0]              cand;
    logic [NUM_REQ-1:0]       sel_onehot;
    logic [PW-1:0]            next_rr;
    logic [LW-1:0]            raw_len;
    logic [LW-1:0]            clamped_len;
    logic [MESSAGE_WIDTH-1:0] sel_pattern;
    logic                     tick_end;
    logic                     zero_len;
    logic                     last_bit;
    logic                     play_done;
    logic                     gap_end;
    logic                     abort_now;

    // Search from rr_ptr upward with wrap; the first valid requester wins.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (PW+1)'(k);
            if (cand >= (PW+1)'(NUM_REQ)) begin
                cand = cand - (PW+1)'(NUM_REQ);
            end
            if (!found && REQ_VALID[cand[PW-1:0]]) begin
                found = 1'b1;
                sel   = cand[PW-1:0];
            end
        end
    end

    assign sel_onehot  = NUM_REQ'(1) << sel;
    assign next_rr     = (sel == PW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
    assign sel_pattern = REQ_PATTERN[int'(sel)*MESSAGE_WIDTH +: MESSAGE_WIDTH];
    assign raw_len     = REQ_LEN[int'(sel)*LW +: LW];
    assign clamped_len = (raw_len > LW'(MESSAGE_WIDTH)) ? LW'(MESSAGE_WIDTH) : raw_len;

    assign REQ_READY = (state == S_IDLE && found && !RST) ? sel_onehot : '0;

    assign tick_end  = (tick == TW'(TICK_RATE - 1));
    assign zero_len  = (len == '0);
    assign last_bit  = (LW'(bit_idx) == len - LW'(1));
    assign play_done = (state == S_PLAY) && (zero_len || (tick_end && last_bit));
    assign gap_end   = tick_end && (gap_idx == GW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0));

`ifdef BLINK_SCHED_ABORT_EN
    assign abort_now = ABORT && (state != S_IDLE);
`else
    assign abort_now = 1'b0;
`endif

    // An abort overrides every normal transition and suppresses DONE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= S_IDLE;
            rr_ptr  <= '0;
            tick    <= '0;
            bit_idx <= '0;
            gap_idx <= '0;
            len     <= '0;
            pattern <= '0;
            grant   <= '0;
        end else if (abort_now) begin
            state <= S_IDLE;
            grant <= '0;
            tick  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        pattern <= sel_pattern;
                        len     <= clamped_len;
                        grant   <= sel_onehot;
                        rr_ptr  <= next_rr;
                        tick    <= '0;
                        bit_idx <= '0;
                        state   <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (play_done) begin
                        tick    <= '0;
                        gap_idx <= '0;
                        if (GAP_TICKS > 0) begin
                            state <= S_GAP;
                        end else begin
                            state <= S_IDLE;
                            grant <= '0;
                        end
                    end else if (tick_end) begin
                        tick    <= '0;
                        bit_idx <= bit_idx + 1'b1;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                S_GAP: begin
                    if (tick_end) begin
                        tick <= '0;
                        if (gap_end) begin
                            state <= S_IDLE;
                            grant <= '0;
                        end else begin
                            gap_idx <= gap_idx + 1'b1;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    assign LED   = (state == S_PLAY) && !zero_len && pattern[bit_idx];
    assign START = (state == S_PLAY) && !zero_len && (bit_idx == '0);
    assign BUSY  = (state != S_IDLE);
    assign GRANT = grant;
    assign DONE  = play_done && !abort_now;

endmodule

// File: tb/tb_blink_pattern_scheduler.sv
// Testbench for blink_pattern_scheduler: directed vector table, reset-in-flight sequence,
// and randomized messages checked against a message-level timeline model.
module tb_blink_pattern_scheduler;

    localparam int NR  = 2;
    localparam int MW  = 8;
    localparam int TR  = 4;
    localparam int GAP = 1;
    localparam int LW  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*MW-1:0] req_pattern;
    logic [NR*LW-1:0] req_len;
    logic            led;
    logic            start;
    logic            busy;
    logic [NR-1:0]   grant;
    logic            done;
    logic            abort;

    int n_checks = 0;
    int n_passed = 0;
    int model_rr = 0;

    typedef struct {
        logic [1:0] valid;
        logic [7:0] p0;
        logic [7:0] p1;
        logic [3:0] l0;
        logic [3:0] l1;
        int         exp_winner;
        logic [7:0] exp_pat;
        int         exp_bits;
    } vec_t;

    vec_t vecs[9];

    blink_pattern_scheduler #(
        .NUM_REQ(NR),
        .MESSAGE_WIDTH(MW),
        .TICK_RATE(TR),
        .GAP_TICKS(GAP)
    ) dut (
        .CLK(clk),
        .RST(rst),
`ifdef BLINK_SCHED_ABORT_EN
        .ABORT(abort),
`endif
        .REQ_VALID(req_valid),
        .REQ_READY(req_ready),
        .REQ_PATTERN(req_pattern),
        .REQ_LEN(req_len),
        .LED(led),
        .START(start),
        .BUSY(busy),
        .GRANT(grant),
        .DONE(done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_passed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    task automatic apply_stimulus(input logic [1:0] v, input logic [7:0] p0, input logic [7:0] p1,
                                  input logic [3:0] l0, input logic [3:0] l1);
        req_valid   = v;
        req_pattern = {p1, p0};
        req_len     = {l1, l0};
    endtask

    task automatic scramble();
        req_valid   = 2'($urandom);
        req_pattern = 16'($urandom);
        req_len     = 8'($urandom);
    endtask

    function automatic int model_winner(input logic [1:0] v);
        for (int k = 0; k < NR; k++) begin
            int idx;
            idx = (model_rr + k) % NR;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // Called at a negedge with the DUT idle; plays out the whole expected timeline.
    task automatic run_message(input logic [1:0] v, input logic [7:0] p0, input logic [7:0] p1,
                               input logic [3:0] l0, input logic [3:0] l1,
                               input int exp_winner, input logic [7:0] exp_pat, input int exp_bits);
        logic [1:0] g;
        int play_cycles;
        apply_stimulus(v, p0, p1, l0, l1);
        #1;
        check_output("ready_idle", req_ready, (exp_winner < 0) ? 0 : (1 << exp_winner));
        if (exp_winner < 0) begin
            @(negedge clk);
            check_output("busy_idle", busy, 0);
            return;
        end
        model_rr = (exp_winner + 1) % NR;
        g = 2'(1 << exp_winner);
        play_cycles = (exp_bits == 0) ? 1 : exp_bits * TR;
        for (int t = 0; t < play_cycles; t++) begin
            @(negedge clk);
            check_output("led_play", led, (exp_bits == 0) ? 0 : exp_pat[t / TR]);
            check_output("done_play", done, (t == play_cycles - 1) ? 1 : 0);
            check_output("busy_play", busy, 1);
            check_output("grant_play", grant, g);
            check_output("ready_play", req_ready, 0);
            if (exp_bits > 0) check_output("start_play", start, (t < TR) ? 1 : 0);
            scramble();
        end
        for (int t = 0; t < GAP * TR; t++) begin
            @(negedge clk);
            check_output("led_gap", led, 0);
            check_output("done_gap", done, 0);
            check_output("busy_gap", busy, 1);
            check_output("grant_gap", grant, g);
            check_output("ready_gap", req_ready, 0);
            scramble();
        end
        @(negedge clk);
        check_output("busy_after", busy, 0);
        check_output("grant_after", grant, 0);
        check_output("led_after", led, 0);
        check_output("done_after", done, 0);
    endtask

    initial begin
        logic [1:0] v;
        logic [7:0] p0, p1;
        logic [3:0] l0, l1;
        int w, bits, lw;

        vecs[0] = '{2'b01, 8'h0D, 8'h00, 4'd4,  4'd0, 0,  8'h0D, 4};
        vecs[1] = '{2'b11, 8'hAA, 8'h55, 4'd8,  4'd8, 1,  8'h55, 8};
        vecs[2] = '{2'b11, 8'h3C, 8'hC3, 4'd3,  4'd5, 0,  8'h3C, 3};
        vecs[3] = '{2'b11, 8'hF0, 8'h81, 4'd2,  4'd6, 1,  8'h81, 6};
        vecs[4] = '{2'b10, 8'h00, 8'hFF, 4'd0,  4'd0, 1,  8'hFF, 0};
        vecs[5] = '{2'b01, 8'hB7, 8'h00, 4'd15, 4'd0, 0,  8'hB7, 8};
        vecs[6] = '{2'b01, 8'h96, 8'h00, 4'd1,  4'd0, 0,  8'h96, 1};
        vecs[7] = '{2'b11, 8'h11, 8'h6E, 4'd2,  4'd7, 1,  8'h6E, 7};
        vecs[8] = '{2'b00, 8'h00, 8'h00, 4'd0,  4'd0, -1, 8'h00, 0};

        rst   = 1'b1;
        abort = 1'b0;
        apply_stimulus(2'b11, 8'hFF, 8'hFF, 4'd4, 4'd4);
        @(negedge clk);
        check_output("rst_led", led, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_grant", grant, 0);
        check_output("rst_done", done, 0);
        check_output("rst_start", start, 0);
        check_output("rst_ready", req_ready, 0);
        apply_stimulus(2'b00, 8'h00, 8'h00, 4'd0, 4'd0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_message(vecs[i].valid, vecs[i].p0, vecs[i].p1, vecs[i].l0, vecs[i].l1,
                        vecs[i].exp_winner, vecs[i].exp_pat, vecs[i].exp_bits);
        end

        // Reset in the middle of a message from requester 0, leaving rr pointing at 1.
        apply_stimulus(2'b01, 8'hFF, 8'h00, 4'd4, 4'd0);
        #1;
        check_output("ready_pre_rst", req_ready, 2'b01);
        @(negedge clk);
        @(negedge clk);
        check_output("led_pre_rst", led, 1);
        rst = 1'b1;
        #1;
        check_output("rst_mid_led", led, 0);
        check_output("rst_mid_busy", busy, 0);
        check_output("rst_mid_grant", grant, 0);
        check_output("rst_mid_done", done, 0);
        check_output("rst_mid_ready", req_ready, 0);
        apply_stimulus(2'b11, 8'h5A, 8'hA5, 4'd4, 4'd4);
        @(negedge clk);
        rst = 1'b0;
        model_rr = 0;
        run_message(2'b11, 8'h5A, 8'hA5, 4'd4, 4'd4, 0, 8'h5A, 4);

        for (int i = 0; i < 25; i++) begin
            v  = ($urandom_range(0, 5) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            p0 = 8'($urandom);
            p1 = 8'($urandom);
            l0 = 4'($urandom);
            l1 = 4'($urandom);
            w  = model_winner(v);
            lw = (w == 1) ? int'(l1) : int'(l0);
            bits = (lw > MW) ? MW : lw;
            run_message(v, p0, p1, l0, l1, w, (w == 1) ? p1 : p0, bits);
        end

`ifdef BLINK_SCHED_ABORT_EN
        apply_stimulus(2'b11, 8'hFF, 8'hFF, 4'd8, 4'd8);
        w = model_winner(2'b11);
        #1;
        check_output("ready_abort", req_ready, 1 << w);
        model_rr = (w + 1) % NR;
        for (int t = 0; t <= 2 * TR; t++) @(negedge clk);
        abort = 1'b1;
        #1;
        check_output("done_abort", done, 0);
        check_output("busy_abort", busy, 1);
        @(negedge clk);
        check_output("busy_post_abort", busy, 0);
        check_output("grant_post_abort", grant, 0);
        check_output("led_post_abort", led, 0);
        abort = 1'b0;
        apply_stimulus(2'b11, 8'h00, 8'h00, 4'd1, 4'd1);
        #1;
        check_output("ready_post_abort", req_ready, 1 << model_rr);
        @(negedge clk);
`endif

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
